id_ex_stage_skid: RTL

Parametrised ID/EX pipeline stage register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush that inserts a zeroed bubble. It sits between the decode and execute stages. It generalises the fixed 8-bit ID/EX latch to configurable operand, instruction and control widths. Unlike that latch, it can back-pressure decode when execute stalls, without a combinational ready path.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_slot.sv | 26 ++
 rtl/id_ex_stage_skid.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the ID/EX pipeline stage.
package pipe_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 8;
  localparam int CTRL_W  = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
  } entry_t;

  localparam entry_t ZERO_ENTRY = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register with load and clear; clear wins over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      // the zero entry resized to this slot's width
      q <= W'(ZERO_ENTRY);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage_skid.sv
// ID/EX stage register with valid/ready handshake, one-entry skid buffer and flush-to-bubble.
module id_ex_stage_skid #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int INSTR_W = pipe_pkg::INSTR_W,
  parameter int CTRL_W  = pipe_pkg::CTRL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [DATA_W-1:0]  out_b,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [1:0]         occupancy
);
  import pipe_pkg::*;

  localparam int EW = 2*DATA_W + INSTR_W + CTRL_W;

  state_e        state, state_nx;
  logic [EW-1:0] in_entry, main_d, main_q, skid_q;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic          in_xfer, out_xfer;

  assign in_entry = {in_a, in_b, in_instr, in_ctrl};
  assign {out_a, out_b, out_instr, out_ctrl} = main_q;

  // Handshake outputs decode the state register only, never out_ready or flush.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    main_d    = in_entry;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nx  = FULL;
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            state_nx  = SKID;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            // zeroing MAIN on drain keeps the bubble visible as a NOP
            state_nx = EMPTY;
            main_clr = 1'b1;
          end
        end
        SKID: begin
          if (out_xfer) begin
            state_nx  = FULL;
            main_d    = skid_q;
            main_load = 1'b1;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          state_nx = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(.W(EW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(EW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_entry),
    .q     (skid_q)
  );

endmodule
